// File: rtl/uart_rx_if.sv
// uart_rx_if: one-entry valid/ready byte channel between the UART receiver
// and the character store.
//   data  : received byte, LSB = first data bit on the line
//   valid : data holds an unconsumed byte
//   ready : consumer takes the byte in any cycle where valid && ready
// master = producer (receiver), slave = consumer (store).
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-bit qualification, mid-bit sampling,
// framing-error detection and a one-entry valid/ready output buffer.
// Ports:
//   sysclk    : system clock, rising edge
//   reset     : synchronous, active-high
//   serialIn  : asynchronous RX line, idles high
//   clear_err : one-cycle pulse, clears the sticky overrun flag
//   bus       : uart_rx_if.master (data/valid out, ready in)
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky, a completed byte was dropped because the buffer was full
//   busy      : high in every state except IDLE
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        serialIn,
  input  logic        clear_err,
  uart_rx_if.master   bus,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_p0;
  logic             rx_s;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       idx;
  logic [2:0]       idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             deliver;
  logic             stop_bad;

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level here was a glitch.
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        // Counter was aligned to mid-start, so its wrap lands mid-bit.
        if (cnt == LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off while the line is in break so it is not seen as new starts.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_p0     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      bus.data  <= 8'h00;
      bus.valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Stage p0 -> rx_s: two-flop synchroniser on the asynchronous line.
      rx_p0     <= serialIn;
      rx_s      <= rx_p0;
      // Receive FSM and bit-timing state.
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      frame_err <= stop_bad;
      // Output buffer: a consume and a delivery in the same cycle reload
      // without a bubble; a delivery into a full, unconsumed buffer is dropped.
      if (deliver) begin
        if (!bus.valid || bus.ready) begin
          bus.data  <= shift;
          bus.valid <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
      // A new overrun event takes priority over clear_err.
      if (deliver && bus.valid && !bus.ready) overrun <= 1'b1;
      else if (clear_err)                     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int C   = 16;
  // Cycles from the edge after which serialIn falls to the edge that loads
  // valid: 2 synchroniser edges + (C/2 + 9*C) to the stop sample + 1.
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  logic sysclk    = 1'b0;
  logic reset     = 1'b1;
  logic serialIn  = 1'b1;
  logic clear_err = 1'b0;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .serialIn  (serialIn),
    .clear_err (clear_err),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int   v_high   = 0;
  int   v_fall   = 0;
  int   fe_cnt   = 0;
  int   busy_cnt = 0;
  int   rise_cyc = -1;
  logic prev_v   = 1'b0;
  always @(negedge sysclk) begin
    if (bus.valid) v_high++;
    if (!bus.valid && prev_v) v_fall++;
    if (bus.valid && !prev_v) rise_cyc = cyc;
    if (frame_err) fe_cnt++;
    if (busy) busy_cnt++;
    prev_v = bus.valid;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    serialIn = v;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Reference-model scoreboard: byte and the edge at which it must be offered.
  int         q_edge[$];
  logic [7:0] q_byte[$];

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit track,
                            output int st);
    @(posedge sysclk);
    #1;
    st = cyc;
    if (track) begin
      q_edge.push_back(st + LAT);
      q_byte.push_back(b);
    end
    drive_bit(1'b0, C);
    for (int i = 0; i < 8; i++) drive_bit(b[i], C);
    drive_bit(stop, C);
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #1 reset = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_v;
    logic [7:0] exp_d;
    int         exp_fe;
  } vec_t;

  vec_t       tbl[7];
  int         st;
  int         v0, f0, b0, vf0;
  logic [7:0] rb;
  logic [7:0] lb;
  logic       dl, ov_set, mv, mo;
  logic [7:0] md;
  bit         done;

  initial begin
    tbl[0] = '{8'h41, 1'b1, 1'b1, 8'h41, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
    tbl[5] = '{8'h55, 1'b0, 1'b0, 8'h00, 1};
    tbl[6] = '{8'hAA, 1'b0, 1'b0, 8'h00, 1};

    bus.ready = 1'b0;
    do_reset();
    chk("rst_valid", bus.valid, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);

    // Table: single frames from a clean reset, buffer not consumed.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.ready = 1'b0;
      f0 = fe_cnt;
      send_frame(tbl[i].b, tbl[i].stop, 1'b0, st);
      drive_bit(1'b1, 8);
      chk($sformatf("tbl%0d_valid", i), bus.valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_data", i), bus.data, tbl[i].exp_d);
      chk($sformatf("tbl%0d_fe", i), fe_cnt - f0, tbl[i].exp_fe);
      chk($sformatf("tbl%0d_overrun", i), overrun, 0);
    end

    // 0x41 with ready held high: one-cycle valid at the exact latency.
    do_reset();
    bus.ready = 1'b1;
    v0 = v_high; f0 = fe_cnt;
    send_frame(8'h41, 1'b1, 1'b0, st);
    drive_bit(1'b1, 10);
    chk("a_valid_cycles", v_high - v0, 1);
    chk("a_latency", rise_cyc - st, LAT);
    chk("a_data", bus.data, 8'h41);
    chk("a_fe", fe_cnt - f0, 0);

    // 4-cycle low glitch: busy for the half-bit check only, then idle.
    v0 = v_high; f0 = fe_cnt; b0 = busy_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    chk("glitch_busy_cycles", busy_cnt - b0, C / 2);
    chk("glitch_valid", v_high - v0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_busy_end", busy, 0);

    // Framing error followed by a held-low line, then a good frame.
    v0 = v_high; f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, st);
    drive_bit(1'b0, 40);
    chk("brk_busy", busy, 1);
    chk("brk_fe", fe_cnt - f0, 1);
    chk("brk_valid", v_high - v0, 0);
    drive_bit(1'b1, 4);
    chk("brk_idle", busy, 0);
    bus.ready = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0, st);
    drive_bit(1'b1, 4);
    chk("brk_next_valid", bus.valid, 1);
    chk("brk_next_data", bus.data, 8'h7E);

    // Overrun with ready low, then clear_err.
    bus.ready = 1'b1;
    drive_bit(1'b1, 1);
    bus.ready = 1'b0;
    drive_bit(1'b1, 2);
    chk("consume_7e", bus.valid, 0);
    send_frame(8'h31, 1'b1, 1'b0, st);
    send_frame(8'h32, 1'b1, 1'b0, st);
    drive_bit(1'b1, 4);
    chk("ovr_data", bus.data, 8'h31);
    chk("ovr_valid", bus.valid, 1);
    chk("ovr_flag", overrun, 1);
    clear_err = 1'b1;
    drive_bit(1'b1, 1);
    clear_err = 1'b0;
    drive_bit(1'b1, 2);
    chk("clr_flag", overrun, 0);
    chk("clr_data", bus.data, 8'h31);

    // Consume and deliver in the same cycle: no bubble, no overrun.
    bus.ready = 1'b1;
    drive_bit(1'b1, 1);
    bus.ready = 1'b0;
    send_frame(8'h10, 1'b1, 1'b0, st);
    drive_bit(1'b1, 4);
    chk("b2b_first", bus.data, 8'h10);
    vf0 = v_fall;
    fork
      send_frame(8'h20, 1'b1, 1'b0, st);
      begin
        repeat (LAT) @(posedge sysclk);
        #1 bus.ready = 1'b1;
        @(posedge sysclk);
        #1 bus.ready = 1'b0;
      end
    join
    drive_bit(1'b1, 4);
    chk("b2b_data", bus.data, 8'h20);
    chk("b2b_valid", bus.valid, 1);
    chk("b2b_no_bubble", v_fall - vf0, 0);
    chk("b2b_overrun", overrun, 0);

    // Reset in the middle of data bit 3 of 0xA5; the sender abandons too.
    lb = 8'hA5;
    drive_bit(1'b0, C);
    for (int i = 0; i < 3; i++) drive_bit(lb[i], C);
    drive_bit(lb[3], C / 2);
    reset    = 1'b1;
    serialIn = 1'b1;
    @(posedge sysclk);
    #1 reset = 1'b0;
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_fe", frame_err, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    v0 = v_high; f0 = fe_cnt;
    drive_bit(1'b1, 200);
    chk("mid_rst_no_valid", v_high - v0, 0);
    chk("mid_rst_no_fe", fe_cnt - f0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, st);
    drive_bit(1'b1, 4);
    chk("mid_rst_next_valid", bus.valid, 1);
    chk("mid_rst_next_data", bus.data, 8'hC3);

    // Random frames, random ready and clear_err, against a buffer model.
    do_reset();
    bus.ready = 1'b0;
    clear_err = 1'b0;
    mv = 1'b0; mo = 1'b0; md = 8'h00;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 25; f++) begin
          send_frame(8'($urandom), 1'b1, 1'b1, st);
          drive_bit(1'b1, $urandom_range(0, 30));
        end
        drive_bit(1'b1, 8);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge sysclk);
          #1;
          dl = (q_edge.size() > 0) && (q_edge[0] == cyc);
          ov_set = 1'b0;
          if (dl) begin
            rb = q_byte.pop_front();
            void'(q_edge.pop_front());
            if (!mv || bus.ready) begin
              md = rb;
              mv = 1'b1;
            end else begin
              ov_set = 1'b1;
            end
          end else if (mv && bus.ready) begin
            mv = 1'b0;
          end
          if (ov_set) mo = 1'b1;
          else if (clear_err) mo = 1'b0;
          bus.ready = 1'($urandom_range(0, 1));
          clear_err = ($urandom_range(0, 7) == 0);
          @(negedge sysclk);
          chk("rnd_valid", bus.valid, mv);
          if (mv) chk("rnd_data", bus.data, md);
          chk("rnd_overrun", overrun, mo);
          chk("rnd_fe", frame_err, 0);
        end
      end
    join
    chk("rnd_all_delivered", q_edge.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
